acc_adder_4bit: RTL and testbench



---
 rtl/acc_adder_4bit_if.sv | 25 ++
 rtl/acc_adder_4bit.sv | 94 +++++++++
 tb/tb_acc_adder_4bit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/acc_adder_4bit_if.sv
// Operand/result handshake bundle between the adder datapath consumer and acc_adder_4bit.
interface acc_adder_4bit_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             start;
   logic             C_in;
   logic [WIDTH-1:0] B;
   logic             B_valid;
   logic             B_ready;
   logic [WIDTH-1:0] S;
   logic [CNT_W-1:0] Carry_cnt;
   logic             Res_valid;
   logic             Res_ready;

   modport master (
      output start, C_in, B, B_valid, Res_ready,
      input  B_ready, S, Carry_cnt, Res_valid
   );

   modport slave (
      input  start, C_in, B, B_valid, Res_ready,
      output B_ready, S, Carry_cnt, Res_valid
   );
endinterface

// File: rtl/acc_adder_4bit.sv
// Multi-operand accumulator: result valid the cycle after the N_OPS-th accepted operand; B_ready only in ACC, result held until Res_ready.
// Optional macro ACC_SATURATE_EN: clamp S to all ones on any carry-out instead of wrapping.
module acc_adder_4bit #(
   parameter int WIDTH = 4,
   parameter int N_OPS = 4,
   parameter int CNT_W = 3
) (
   input logic               clk,
   input logic               rst_n,
   acc_adder_4bit_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] s_q;
   logic [CNT_W-1:0] carry_q;
   logic [CNT_W-1:0] op_cnt_q;
   logic             cin_q;

   logic             hs;
   logic             first_cin;
   logic             last_op;
   logic [WIDTH:0]   sum_ext;
   logic             b_ready;
   logic             res_valid;

   // Carry-in only joins the very first operand of a run.
   assign first_cin = (op_cnt_q == '0) ? cin_q : 1'b0;
   assign sum_ext   = {1'b0, s_q} + {1'b0, bus.B} + (WIDTH+1)'(first_cin);
   assign hs        = bus.B_valid & b_ready;
   assign last_op   = (op_cnt_q == CNT_W'(N_OPS - 1));

   always_comb begin
      state_d   = state_q;
      b_ready   = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = ACC;
         end
         ACC: begin
            b_ready = 1'b1;
            if (bus.B_valid && last_op) state_d = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (bus.Res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q      <= '0;
         carry_q  <= '0;
         op_cnt_q <= '0;
         cin_q    <= 1'b0;
      end else if (state_q == IDLE && bus.start) begin
         s_q      <= '0;
         carry_q  <= '0;
         op_cnt_q <= '0;
         cin_q    <= bus.C_in;
      end else if (hs) begin
`ifdef ACC_SATURATE_EN
         s_q <= sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
         s_q <= sum_ext[WIDTH-1:0];
`endif
         // Carry counter sticks at its maximum rather than wrapping.
         if (sum_ext[WIDTH] && carry_q != '1) carry_q <= carry_q + CNT_W'(1);
         op_cnt_q <= op_cnt_q + CNT_W'(1);
      end
   end

   assign bus.B_ready   = b_ready;
   assign bus.Res_valid = res_valid;
   assign bus.S         = s_q;
   assign bus.Carry_cnt = carry_q;

endmodule

// File: tb/tb_acc_adder_4bit.sv
// Randomized and directed bench for acc_adder_4bit against an arithmetic reference model.
module tb_acc_adder_4bit;
   localparam int WIDTH = 4;
   localparam int N_OPS = 4;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [WIDTH-1:0] ops [N_OPS];

   acc_adder_4bit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   acc_adder_4bit #(.WIDTH(WIDTH), .N_OPS(N_OPS), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer sum of the operands plus carry-in once.
   task automatic model(input logic cin, output int s, output int c);
      int acc;
      int t;
      acc = 0;
      c   = 0;
      for (int i = 0; i < N_OPS; i++) begin
         t = acc + int'(ops[i]) + ((i == 0) ? int'(cin) : 0);
         if (t >= (1 << WIDTH)) begin
            c++;
`ifdef ACC_SATURATE_EN
            t = (1 << WIDTH) - 1;
`endif
         end
         acc = t % (1 << WIDTH);
      end
      if (c > (1 << CNT_W) - 1) c = (1 << CNT_W) - 1;
      s = acc;
   endtask

   // gap: 0 = B_valid held high, 1 = toggled, 2 = random
   task automatic run_ops(input logic cin, input int gap, input int hold);
      int  exp_s, exp_c, n, cyc;
      logic v;
      model(cin, exp_s, exp_c);
      @(negedge clk);
      bus.start = 1'b1;
      bus.C_in  = cin;
      @(negedge clk);
      bus.start = 1'b0;
      bus.C_in  = 1'b0;
      n = 0;
      cyc = 0;
      while (n < N_OPS && cyc < 100) begin
         case (gap)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.B_valid = v;
         bus.B       = v ? ops[n] : 4'($urandom_range(0, 15));
         check("acc_b_ready", 32'(bus.B_ready), 1);
         check("acc_res_valid", 32'(bus.Res_valid), 0);
         if (v) n++;
         cyc++;
         @(negedge clk);
      end
      bus.B_valid = 1'b0;
      check("accept_count", n, N_OPS);
      if (gap == 0) check("acc_cycles", cyc, N_OPS);
      check("done_res_valid", 32'(bus.Res_valid), 1);
      check("done_b_ready", 32'(bus.B_ready), 0);
      check("done_s", 32'(bus.S), exp_s);
      check("done_carry", 32'(bus.Carry_cnt), exp_c);
      for (int h = 0; h < hold; h++) begin
         bus.Res_ready = 1'b0;
         bus.start     = (h == 1);
         @(negedge clk);
         check("hold_res_valid", 32'(bus.Res_valid), 1);
         check("hold_s", 32'(bus.S), exp_s);
      end
      bus.start     = 1'b1;
      bus.Res_ready = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.Res_ready = 1'b0;
      check("idle_res_valid", 32'(bus.Res_valid), 0);
      check("idle_b_ready", 32'(bus.B_ready), 0);
      check("idle_s", 32'(bus.S), exp_s);
      check("idle_carry", 32'(bus.Carry_cnt), exp_c);
      @(negedge clk);
      check("idle_no_restart", 32'(bus.B_ready), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.C_in      = 1'b0;
      bus.B         = '0;
      bus.B_valid   = 1'b0;
      bus.Res_ready = 1'b0;
      #1;
      check("rst_s", 32'(bus.S), 0);
      check("rst_carry", 32'(bus.Carry_cnt), 0);
      check("rst_b_ready", 32'(bus.B_ready), 0);
      check("rst_res_valid", 32'(bus.Res_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic run
      ops[0] = 4'h1; ops[1] = 4'h1; ops[2] = 4'h3; ops[3] = 4'h2;
      run_ops(1'b0, 0, 0);
      // Carry/wrap or saturate
      ops[0] = 4'hF; ops[1] = 4'h1; ops[2] = 4'hF; ops[3] = 4'hF;
      run_ops(1'b0, 0, 1);
      // Carry-in only on first operand
      ops[0] = 4'h2; ops[1] = 4'h0; ops[2] = 4'h0; ops[3] = 4'h0;
      run_ops(1'b1, 0, 0);
      // Toggled valid and long result backpressure
      ops[0] = 4'h4; ops[1] = 4'h9; ops[2] = 4'h7; ops[3] = 4'hC;
      run_ops(1'b1, 1, 5);

      // Asynchronous reset mid-run after two operands
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.B_valid = 1'b1;
      bus.B       = 4'h5;
      @(negedge clk);
      @(negedge clk);
      bus.B_valid = 1'b0;
      check("pre_rst_s", 32'(bus.S), 32'h0A);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_s", 32'(bus.S), 0);
      check("mid_rst_carry", 32'(bus.Carry_cnt), 0);
      check("mid_rst_b_ready", 32'(bus.B_ready), 0);
      check("mid_rst_res_valid", 32'(bus.Res_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ops[0] = 4'h1; ops[1] = 4'h1; ops[2] = 4'h1; ops[3] = 4'h1;
      run_ops(1'b0, 0, 0);

      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N_OPS; i++) ops[i] = 4'($urandom_range(0, 15));
         run_ops(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
